reg_checkpoint_ctrl: RTL
========================

// Module: reg_checkpoint_ctrl
// PURPOSE
//  Allocates, stores, releases and restores register-file checkpoints for speculative branches.
//  Sits between decode/branch-resolve and reg_file.
//  Captures the architectural regs (plus same-cycle write-back) on a branch.
//  On mispredict: sequences recover_snapshot -> done -> recovery_done_ack.
// PARAMETERS
//  NUM_CKPT    4   checkpoint slots; power of 2, >=2
//  DATA_WIDTH  32  register width (matches `DATA_WIDTH)
//  NUM_REGS    32  architectural registers
//  TAG_W       $clog2(NUM_CKPT)  slot tag width (derived, not overridden)
// PORTS
//  clk               in   1                  clock
//  rst_n             in   1                  reset, asynchronous, active-low
//  take_req          in   1                  checkpoint request (branch in decode)
//  take_ready        out  1                  slot free and FSM idle
//  take_tag          out  TAG_W              tag for this cycle's allocation
//  regs_in           in   DATA_WIDTH x NUM_REGS  live regs from reg_file regs_out
//  wb_uses_rw        in   1                  same-cycle write-back valid
//  wb_rw_addr        in   5                  same-cycle write-back address
//  wb_rw_data        in   DATA_WIDTH         same-cycle write-back data
//  release_valid     in   1                  oldest branch resolved correct
//  release_tag       in   TAG_W              tag being released
//  mispredict_valid  in   1                  branch mispredicted
//  mispredict_tag    in   TAG_W              tag to restore
//  recover_snapshot  out  1                  to reg_file: load regs_snapshot
//  regs_snapshot     out  DATA_WIDTH x NUM_REGS  slot data being restored
//  rf_done           in   1                  reg_file done
//  recovery_done_ack out  1                  to reg_file/front end: recovery complete
//  busy              out  1                  recovery in progress; upstream stalls
//  err               out  1                  sticky protocol error
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FSM=IDLE; head=tail=0; count=0; err=0.
//   - recover_snapshot, recovery_done_ack and busy are 0.
//   - take_ready is 1 once reset is released; slot data is not reset.
//  Allocation: circular buffer.
//   - take_tag=tail.
//   - take_ready = IDLE && count<NUM_CKPT && !mispredict_valid.
//   - On take_req&&take_ready: slot[tail] <= regs_in, with wb_rw_data merged at wb_rw_addr when
//     wb_uses_rw (addr 0 included, same as reg_file); tail++ (wraps); count++.
//   - take_req while !take_ready: ignored, no error.
//  Release: in-order only.
//   - Accepted in IDLE when count>0 and release_tag==head: head++ (wraps), count--.
//   - Wrong tag or count==0: ignored, err<=1.
//   - Same-cycle take+release: both apply; count unchanged; take_ready uses the pre-edge count
//     (full+release still rejects take).
//  Mispredict: in IDLE, tag valid iff (mispredict_tag-head) mod NUM_CKPT < count.
//   - Valid: latch rec_tag; ->RECOVER. Same-cycle release_valid is ignored.
//   - Invalid: ignored, err<=1.
//  FSM states IDLE, RECOVER, WAIT_DONE, ACK:
//   - RECOVER: recover_snapshot=1 for exactly 1 cycle -> WAIT_DONE.
//   - WAIT_DONE: wait for rf_done=1 -> ACK (no timeout).
//   - ACK: recovery_done_ack=1 for 1 cycle. Free rec_tag and all younger slots:
//     tail<=rec_tag, count<=(rec_tag-head) mod NUM_CKPT. -> IDLE.
//   - regs_snapshot=slot[rec_tag], stable from RECOVER through ACK (don't-care in IDLE).
//   - busy=1 in RECOVER, WAIT_DONE and ACK.
//   - All take/release/mispredict inputs are ignored while busy, with no err.
//  Latency: mispredict_valid@T -> recover_snapshot@T+1 -> ack 1 cycle after rf_done is seen.
//  Reset mid-recovery: immediate IDLE; outputs 0; all slots freed.
// STRUCTURE
//  Package reg_ckpt_pkg:
//   - ckpt_state_e {IDLE,RECOVER,WAIT_DONE,ACK}; reg_array_t (DATA_WIDTH x NUM_REGS).
//  Sub-module ckpt_storage:
//   - NUM_CKPT x reg_array_t flops; write port with WB merge; async read by rec_tag; no reset.
//  Top level: pointers, count, validity check and FSM.
// TESTING
//  1. Reset -> take_ready=1, busy=0, recover_snapshot=0, recovery_done_ack=0, err=0, take_tag=0.
//  2. Take 4 (tags 0..3) -> take_ready=0; 5th take ignored; release 0 -> take_ready=1;
//     next take gets tag 0 (wrap).
//  3. Take with wb_uses_rw=1, addr=5, data=32'hDEAD_BEEF, regs_in[5]=0 -> restoring that slot
//     gives regs_snapshot[5]=32'hDEAD_BEEF.
//  4. Tags 0,1,2 live; mispredict tag 1 -> recover_snapshot 1 cycle; rf_done after 3 cycles ->
//     ack 1 cycle; then count=1, next take_tag=1.
//  5. release_tag=2 with head=0 -> err=1, state unchanged; mispredict of unallocated tag ->
//     err=1, no recovery.
//  6. rst_n low during WAIT_DONE -> busy=0, count=0, recovery_done_ack never asserted.

Source files
------------

// File: rtl/reg_ckpt_pkg.sv
// Shared types and default sizes for the register-file checkpoint controller.
// Recovery FSM encoding and the flattened register-file image type live here.
package reg_ckpt_pkg;

    localparam int CKPT_NUM_DEFAULT   = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int NUM_REGS_DEFAULT   = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        WAIT_DONE,
        ACK
    } ckpt_state_e;

    typedef logic [NUM_REGS_DEFAULT-1:0][DATA_WIDTH_DEFAULT-1:0] reg_array_t;

endpackage

// File: rtl/ckpt_storage.sv
// Checkpoint slot storage: one full register-file image per slot.
// Write merges the same-cycle write-back; read is combinational by tag.
module ckpt_storage
    import reg_ckpt_pkg::*;
#(
    parameter int NUM_CKPT   = CKPT_NUM_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT,
    parameter int TAG_W      = $clog2(NUM_CKPT)
) (
    input  logic                                 clk,
    input  logic                                 wr_en_i,
    input  logic [TAG_W-1:0]                     wr_tag_i,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_i,
    input  logic                                 wb_en_i,
    input  logic [4:0]                           wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                wb_data_i,
    input  logic [TAG_W-1:0]                     rd_tag_i,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  rd_data_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] slot_q [NUM_CKPT];
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wr_data;

    // The write-back bypass covers register 0 too, mirroring reg_file.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_merge
        assign wr_data[gi] = (wb_en_i && (wb_addr_i == 5'(gi))) ? wb_data_i : regs_i[gi];
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            slot_q[wr_tag_i] <= wr_data;
        end
    end

    assign rd_data_o = slot_q[rd_tag_i];

endmodule

// File: rtl/reg_checkpoint_ctrl.sv
// Checkpoint allocator and mispredict recovery sequencer for the register file.
// Slots form a circular buffer: allocate at tail, release in order at head.
module reg_checkpoint_ctrl
    import reg_ckpt_pkg::*;
#(
    parameter int   NUM_CKPT   = CKPT_NUM_DEFAULT,
    parameter int   DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int   NUM_REGS   = NUM_REGS_DEFAULT,
    localparam int  TAG_W      = $clog2(NUM_CKPT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 take_req,
    output logic                                 take_ready,
    output logic [TAG_W-1:0]                     take_tag,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in,
    input  logic                                 wb_uses_rw,
    input  logic [4:0]                           wb_rw_addr,
    input  logic [DATA_WIDTH-1:0]                wb_rw_data,
    input  logic                                 release_valid,
    input  logic [TAG_W-1:0]                     release_tag,
    input  logic                                 mispredict_valid,
    input  logic [TAG_W-1:0]                     mispredict_tag,
    output logic                                 recover_snapshot,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot,
    input  logic                                 rf_done,
    output logic                                 recovery_done_ack,
    output logic                                 busy,
    output logic                                 err
);

    localparam logic [TAG_W:0]   CKPT_FULL = (TAG_W+1)'(NUM_CKPT);
    localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);

    ckpt_state_e      state_q, state_d;
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [TAG_W-1:0] rec_tag_q, rec_tag_d;
    logic             err_q, err_d;

    logic             take_fire;
    logic             rel_fire;
    logic [TAG_W-1:0] mp_offset;
    logic             mp_hit;
    logic [TAG_W-1:0] keep_count;

    assign take_ready = (state_q == IDLE) && (count_q < CKPT_FULL) && !mispredict_valid;
    assign take_fire  = take_req && take_ready;
    assign take_tag   = tail_q;

    // A tag is live when its distance from head, modulo the ring size, is inside the count.
    assign mp_offset  = mispredict_tag - head_q;
    assign mp_hit     = {1'b0, mp_offset} < count_q;
    assign keep_count = rec_tag_q - head_q;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rec_tag_d = rec_tag_q;
        err_d     = err_q;
        rel_fire  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mispredict_valid && mp_hit) begin
                    rec_tag_d = mispredict_tag;
                    state_d   = RECOVER;
                end else begin
                    if (mispredict_valid) begin
                        err_d = 1'b1;
                    end
                    if (release_valid) begin
                        if ((count_q != '0) && (release_tag == head_q)) begin
                            rel_fire = 1'b1;
                            head_d   = head_q + TAG_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (take_fire) begin
                        tail_d = tail_q + TAG_ONE;
                    end
                    count_d = count_q + (TAG_W+1)'(take_fire) - (TAG_W+1)'(rel_fire);
                end
            end
            RECOVER: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rf_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                // Drop the mispredicted checkpoint and everything allocated after it.
                tail_d  = rec_tag_q;
                count_d = {1'b0, keep_count};
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rec_tag_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rec_tag_q <= rec_tag_d;
            err_q     <= err_d;
        end
    end

    assign recover_snapshot  = (state_q == RECOVER);
    assign recovery_done_ack = (state_q == ACK);
    assign busy              = (state_q != IDLE);
    assign err               = err_q;

    ckpt_storage #(
        .NUM_CKPT   (NUM_CKPT),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .TAG_W      (TAG_W)
    ) u_storage (
        .clk       (clk),
        .wr_en_i   (take_fire),
        .wr_tag_i  (tail_q),
        .regs_i    (regs_in),
        .wb_en_i   (wb_uses_rw),
        .wb_addr_i (wb_rw_addr),
        .wb_data_i (wb_rw_data),
        .rd_tag_i  (rec_tag_q),
        .rd_data_o (regs_snapshot)
    );

endmodule
